reg_scoreboard: RTL

Register-file hazard scheduler between instruction decode and the LEGv8 register file. Tracks one pending-write bit per architectural register, holds off issue of any instruction whose source or destination register has an outstanding write, and clears the bit when the write-back port retires the write. It also provides a drain handshake so the pipeline can be quiesced before branch redirect or debug halt. XZR (register 31) is never tracked.

---
 rtl/reg_scoreboard.sv | 136 +++++++++++++
 1 files changed

// File: rtl/reg_scoreboard.sv
// Register-file hazard scoreboard: one pending-write bit per register, issue hold-off, drain handshake.
// Optional same-cycle write-back bypass of the hazard check: define REG_SCOREBOARD_WB_BYPASS_EN.
module reg_scoreboard #(
  parameter int STALL_CNT_W = 16,
  parameter int ZERO_REG    = 31
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   issue_valid_i,
  output logic                   issue_ready_o,
  input  logic [4:0]             issue_rn_i,
  input  logic                   issue_rn_en_i,
  input  logic [4:0]             issue_rm_i,
  input  logic                   issue_rm_en_i,
  input  logic [4:0]             issue_rd_i,
  input  logic                   issue_rd_en_i,
  input  logic                   wb_valid_i,
  input  logic [4:0]             wb_rd_i,
  input  logic                   drain_req_i,
  output logic                   drain_done_o,
  output logic [31:0]            pending_o,
  output logic                   wb_error_o,
  output logic [STALL_CNT_W-1:0] stall_count_o
);

  localparam logic [4:0] ZR = 5'(ZERO_REG);

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
    S_DRAINED
  } state_e;

  state_e                 state_q;
  logic                   drain_done_q;
  logic [31:0]            pending_q, pending_d;
  logic                   wb_error_q, wb_error_d;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;
  logic [31:0]            hz_vec;
  logic                   hazard, accept;

`ifdef REG_SCOREBOARD_WB_BYPASS_EN
  logic [31:0] wb_mask;

  // A register retiring this cycle no longer blocks its consumer.
  always_comb begin
    wb_mask = '0;
    if (wb_valid_i) wb_mask[wb_rd_i] = 1'b1;
  end

  always_comb begin
    hz_vec           = pending_q & ~wb_mask;
    hz_vec[ZERO_REG] = 1'b0;
  end
`else
  always_comb begin
    hz_vec           = pending_q;
    hz_vec[ZERO_REG] = 1'b0;
  end
`endif

  // WAW also stalls, so each register has at most one write in flight.
  assign hazard = (issue_rn_en_i & hz_vec[issue_rn_i])
                | (issue_rm_en_i & hz_vec[issue_rm_i])
                | (issue_rd_en_i & hz_vec[issue_rd_i]);

  assign issue_ready_o = (state_q == S_RUN) & ~hazard & rst_n_i;
  assign accept        = issue_valid_i & issue_ready_o;

  always_comb begin
    pending_d  = pending_q;
    wb_error_d = wb_error_q;
    if (wb_valid_i) begin
      if (wb_rd_i == ZR || !pending_q[wb_rd_i]) wb_error_d = 1'b1;
      else                                      pending_d[wb_rd_i] = 1'b0;
    end
    // Allocation is applied after retirement so a same-register set wins.
    if (accept && issue_rd_en_i && issue_rd_i != ZR) pending_d[issue_rd_i] = 1'b1;
  end

  always_comb begin
    stall_d = stall_q;
    if (issue_valid_i && !issue_ready_o && stall_q != '1) stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      pending_q  <= '0;
      wb_error_q <= 1'b0;
      stall_q    <= '0;
    end else begin
      pending_q  <= pending_d;
      wb_error_q <= wb_error_d;
      stall_q    <= stall_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q      <= S_RUN;
      drain_done_q <= 1'b0;
    end else begin
      case (state_q)
        S_RUN: begin
          drain_done_q <= 1'b0;
          if (drain_req_i) state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          if (!drain_req_i) begin
            state_q      <= S_RUN;
            drain_done_q <= 1'b0;
          end else if (pending_q == '0) begin
            state_q      <= S_DRAINED;
            drain_done_q <= 1'b1;
          end
        end
        S_DRAINED: begin
          if (!drain_req_i) begin
            state_q      <= S_RUN;
            drain_done_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= S_RUN;
          drain_done_q <= 1'b0;
        end
      endcase
    end
  end

  assign drain_done_o  = drain_done_q;
  assign pending_o     = pending_q;
  assign wb_error_o    = wb_error_q;
  assign stall_count_o = stall_q;

endmodule
